soml_frame_sequencer: RTL and testbench
=======================================

Name: soml_frame_sequencer

Overview:
- Sequences the SOML decoder from a byte stream delivered by the UART receiver.
- Receives one frame holding Y and H, then buffers it and checks its checksum.
- Then pulses the decoder start, replays Y and H words in the decoder's load order, and waits for the decoder result.
- Returns the result (or an error code) as bytes through the UART transmitter handshake. Sits between async_receiver/async_transmitter and the decoder core.

Parameters:
N, 32, decoder word width (fixed 32; byte assembly assumes 4 bytes/word)
SYNC_BYTE, 8'hA5, frame header byte
DEC_TIMEOUT, 4096, max clk cycles to wait for dec_out_valid after last H word
ERR_CKSUM, 8'hEE, response byte on checksum failure
ERR_TMO, 8'hEF, response byte on decode timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rx_data_ready  in  1  one-cycle strobe, new byte on rx_data
rx_data  in  8  received byte
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle strobe to send tx_data
tx_data  out  8  byte to transmit, held stable while tx_start high
dec_start  out  1  one-cycle start pulse to decoder
H_in_valid  out  1  H word strobe
H_in_r / H_in_i  out  N each  H word real/imag
Y_in_valid  out  1  Y word strobe
Y_in_r / Y_in_i  out  N each  Y word real/imag
dec_out_valid  in  1  decoder result strobe
dec_signal  in  12  decoder signal_out_12bit
dec_smin_index  in  5  decoder Smin_index
busy  out  1  high in every state except S_IDLE
frame_err  out  1  sticky; set on checksum fail, cleared on next valid SYNC_BYTE
timeout_err  out  1  sticky; set on decode timeout, cleared on next valid SYNC_BYTE

Behaviour:
- Reset (async):
  - All outputs are 0; state is S_IDLE.
  - Byte, word and cycle counters are 0. Buffer contents are don't-care.
  - Reset mid-frame or mid-decode abandons the operation; no partial output strobes follow.
- Frame layout: SYNC_BYTE, 192 payload bytes, 1 checksum byte.
  - Payload is 24 complex words: Y1[0..3], Y2[0..3], then H row-major H[0][0]..H[3][3].
  - Each complex word is real (4 bytes, MSB first) followed by imag (4 bytes, MSB first).
  - Payload is stored as 48 x 32-bit buffer entries.
  - Checksum = XOR of all 192 payload bytes.
- States:
  - S_IDLE: on rx_data_ready && rx_data==SYNC_BYTE, go to S_RECV and clear both error flags. Other bytes are ignored.
  - S_RECV: shift each byte into the word register; write the buffer every 4th byte; XOR into the running checksum. After byte 192, go to S_CKSUM.
  - S_CKSUM: on the next byte, match -> S_START; mismatch -> set frame_err, load ERR_CKSUM into tx_data, go to S_TX_ERR.
  - S_START: dec_start=1 for exactly 1 cycle (cycle T).
  - S_GAP: cycle T+1, all strobes low.
  - S_SEND_Y: cycles T+2..T+9. Y_in_valid=1 and one complex Y per cycle, in order Y1[0..3] then Y2[0..3]. Imag is passed unnegated (the decoder conjugates).
  - S_SEND_H: cycles T+10..T+25. H_in_valid=1 and one H per cycle, row-major. Y_in_valid and H_in_valid are never high in the same cycle.
  - S_WAIT: count cycles from T+26.
    - dec_out_valid -> capture dec_signal/dec_smin_index and go to S_TX.
    - Count reaching DEC_TIMEOUT -> set timeout_err, load ERR_TMO, go to S_TX_ERR.
    - dec_out_valid in the same cycle the count reaches DEC_TIMEOUT counts as success.
  - S_TX: send 3 bytes in order: {4'h0,sig[11:8]}, sig[7:0], {3'b0,smin}. Return to S_IDLE after byte 3 completes.
  - S_TX_ERR: send the 1 error byte, then return to S_IDLE.
- Per-byte TX handshake:
  - Wait for tx_busy==0, then tx_start=1 for 1 cycle.
  - Ignore tx_busy for the following cycle, then wait for tx_busy==0 before the next byte.
- rx_data_ready is ignored in every state except S_IDLE, S_RECV and S_CKSUM. Bytes during decode or TX are dropped.
- Data outputs hold their last value when the strobe is low. Only the strobes are checked.

Test Plan:
- Nominal frame: H=identity (1.0 = 32'h0040_0000 on the diagonal), Y all 32'h0040_0000 + correct checksum -> dec_start 1 cycle; 8 Y strobes at T+2..T+9; 16 H strobes at T+10..T+25, words match the buffer in order. With dec_out_valid injected (dec_signal=12'hABC, smin=5'd7), tx bytes are 8'h0A, 8'hBC, 8'h07.
- Bad checksum (last byte XOR 8'h01) -> no dec_start, frame_err=1, single tx byte 8'hEE, busy drops.
- Noise before sync: bytes 8'h00, 8'h13, then a valid frame -> noise ignored, frame decoded normally.
- Timeout: dec_out_valid never asserted -> after DEC_TIMEOUT (override to 16) cycles, timeout_err=1 and tx byte 8'hEF. The next SYNC_BYTE clears both flags.
- TX backpressure: hold tx_busy=1 for 100 cycles after each tx_start -> exactly 3 tx_start pulses, each only after tx_busy falls; tx_data stable during each pulse.
- Async reset asserted at H word 5 -> all strobes 0 immediately and state S_IDLE. A fresh full frame afterwards decodes correctly.

Source files
------------

// File: rtl/soml_frame_sequencer.sv
// soml_frame_sequencer
// Collects one SYNC-framed Y/H payload from the UART receiver into a buffer
// and verifies its XOR checksum. It then starts the SOML decoder, replays
// Y and H in load order, waits (with a timeout) for the decoder result, and
// returns the result or an error code byte-by-byte through the UART
// transmitter handshake.
module soml_frame_sequencer #(
  parameter int         N           = 32,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         DEC_TIMEOUT = 4096,
  parameter logic [7:0] ERR_CKSUM   = 8'hEE,
  parameter logic [7:0] ERR_TMO     = 8'hEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_data_ready,
  input  logic [7:0]   rx_data,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic         dec_start,
  output logic         H_in_valid,
  output logic [N-1:0] H_in_r,
  output logic [N-1:0] H_in_i,
  output logic         Y_in_valid,
  output logic [N-1:0] Y_in_r,
  output logic [N-1:0] Y_in_i,
  input  logic         dec_out_valid,
  input  logic [11:0]  dec_signal,
  input  logic [4:0]   dec_smin_index,
  output logic         busy,
  output logic         frame_err,
  output logic         timeout_err
);

  localparam int            CW       = $clog2(DEC_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(DEC_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RECV, S_CKSUM, S_START, S_GAP,
    S_SEND_Y, S_SEND_H, S_WAIT, S_TX, S_TX_ERR
  } state_t;

  state_t        state_r;
  logic [7:0]    byte_cnt_r;
  logic [23:0]   word_r;
  logic [7:0]    cksum_r;
  logic [4:0]    idx_r;
  logic [CW-1:0] wait_cnt_r;
  logic [11:0]   sig_r;
  logic [4:0]    smin_r;
  logic [7:0]    err_code_r;
  logic [1:0]    tx_idx_r;
  logic          tx_hold_r;
  logic [N-1:0]  buf_r [0:47];

  logic          buf_we_s;
  logic [5:0]    buf_waddr_s;
  logic [5:0]    rd_addr_s;
  logic [N-1:0]  rd_re_s;
  logic [N-1:0]  rd_im_s;
  logic [1:0]    tx_total_s;
  logic [7:0]    tx_byte_s;

  // Select the response byte for the current transmit slot.
  function automatic logic [7:0] tx_byte_f(input logic       is_err,
                                           input logic [1:0] idx,
                                           input logic [11:0] sig,
                                           input logic [4:0] smin,
                                           input logic [7:0] err);
    logic [7:0] b;
    if (is_err) begin
      b = err;
    end else begin
      case (idx)
        2'd0:    b = {4'h0, sig[11:8]};
        2'd1:    b = sig[7:0];
        2'd2:    b = {3'b000, smin};
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // Buffer write strobe, replay read address and per-state byte count.
  always_comb begin
    buf_we_s    = 1'b0;
    buf_waddr_s = 6'd0;
    rd_addr_s   = 6'd0;
    tx_total_s  = 2'd0;
    if ((state_r == S_RECV) && rx_data_ready && (byte_cnt_r[1:0] == 2'b11)) begin
      buf_we_s    = 1'b1;
      buf_waddr_s = byte_cnt_r[7:2];
    end else begin
      buf_we_s    = 1'b0;
      buf_waddr_s = 6'd0;
    end
    case (state_r)
      S_SEND_Y: begin
        // After the last Y word the read port already fetches H[0][0].
        if (idx_r == 5'd8) begin
          rd_addr_s = 6'd16;
        end else begin
          rd_addr_s = {idx_r, 1'b0};
        end
      end
      S_SEND_H: begin
        if (idx_r == 5'd16) begin
          rd_addr_s = 6'd0;
        end else begin
          rd_addr_s = 6'd16 + {idx_r, 1'b0};
        end
      end
      default: rd_addr_s = 6'd0;
    endcase
    case (state_r)
      S_TX:     tx_total_s = 2'd3;
      S_TX_ERR: tx_total_s = 2'd1;
      default:  tx_total_s = 2'd0;
    endcase
  end

  assign rd_re_s   = buf_r[rd_addr_s];
  assign rd_im_s   = buf_r[rd_addr_s + 6'd1];
  assign tx_byte_s = tx_byte_f(state_r == S_TX_ERR, tx_idx_r, sig_r, smin_r, err_code_r);

  // Store each completed 32-bit payload word; contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_r[buf_waddr_s] <= {word_r, rx_data};
    end
  end

  // Main sequencer: receive, check, replay to decoder, wait, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      byte_cnt_r  <= 8'd0;
      word_r      <= 24'd0;
      cksum_r     <= 8'd0;
      idx_r       <= 5'd0;
      wait_cnt_r  <= '0;
      sig_r       <= 12'd0;
      smin_r      <= 5'd0;
      err_code_r  <= 8'd0;
      tx_idx_r    <= 2'd0;
      tx_hold_r   <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'd0;
      dec_start   <= 1'b0;
      H_in_valid  <= 1'b0;
      H_in_r      <= '0;
      H_in_i      <= '0;
      Y_in_valid  <= 1'b0;
      Y_in_r      <= '0;
      Y_in_i      <= '0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dec_start <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (rx_data_ready && (rx_data == SYNC_BYTE)) begin
            state_r     <= S_RECV;
            busy        <= 1'b1;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            byte_cnt_r  <= 8'd0;
            cksum_r     <= 8'd0;
          end
        end
        S_RECV: begin
          if (rx_data_ready) begin
            word_r  <= {word_r[15:0], rx_data};
            cksum_r <= cksum_r ^ rx_data;
            if (byte_cnt_r == 8'd191) begin
              byte_cnt_r <= 8'd0;
              state_r    <= S_CKSUM;
            end else begin
              byte_cnt_r <= byte_cnt_r + 8'd1;
            end
          end
        end
        S_CKSUM: begin
          if (rx_data_ready) begin
            if (rx_data == cksum_r) begin
              dec_start <= 1'b1;
              state_r   <= S_START;
            end else begin
              frame_err  <= 1'b1;
              err_code_r <= ERR_CKSUM;
              tx_data    <= ERR_CKSUM;
              tx_idx_r   <= 2'd0;
              tx_hold_r  <= 1'b0;
              state_r    <= S_TX_ERR;
            end
          end
        end
        S_START: begin
          state_r <= S_GAP;
        end
        S_GAP: begin
          Y_in_valid <= 1'b1;
          Y_in_r     <= rd_re_s;
          Y_in_i     <= rd_im_s;
          idx_r      <= 5'd1;
          state_r    <= S_SEND_Y;
        end
        S_SEND_Y: begin
          if (idx_r == 5'd8) begin
            Y_in_valid <= 1'b0;
            H_in_valid <= 1'b1;
            H_in_r     <= rd_re_s;
            H_in_i     <= rd_im_s;
            idx_r      <= 5'd1;
            state_r    <= S_SEND_H;
          end else begin
            Y_in_r <= rd_re_s;
            Y_in_i <= rd_im_s;
            idx_r  <= idx_r + 5'd1;
          end
        end
        S_SEND_H: begin
          if (idx_r == 5'd16) begin
            H_in_valid <= 1'b0;
            wait_cnt_r <= '0;
            state_r    <= S_WAIT;
          end else begin
            H_in_r <= rd_re_s;
            H_in_i <= rd_im_s;
            idx_r  <= idx_r + 5'd1;
          end
        end
        S_WAIT: begin
          // A result arriving on the final allowed cycle still wins.
          if (dec_out_valid) begin
            sig_r     <= dec_signal;
            smin_r    <= dec_smin_index;
            tx_idx_r  <= 2'd0;
            tx_hold_r <= 1'b0;
            state_r   <= S_TX;
          end else if (wait_cnt_r == TMO_LAST) begin
            timeout_err <= 1'b1;
            err_code_r  <= ERR_TMO;
            tx_data     <= ERR_TMO;
            tx_idx_r    <= 2'd0;
            tx_hold_r   <= 1'b0;
            state_r     <= S_TX_ERR;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
        end
        S_TX, S_TX_ERR: begin
          // tx_busy is ignored for one cycle after each pulse, since the
          // transmitter may not have raised it yet.
          if (tx_start) begin
            tx_start  <= 1'b0;
            tx_hold_r <= 1'b1;
          end else if (tx_hold_r) begin
            tx_hold_r <= 1'b0;
          end else if (!tx_busy) begin
            if (tx_idx_r == tx_total_s) begin
              busy    <= 1'b0;
              state_r <= S_IDLE;
            end else begin
              tx_start <= 1'b1;
              tx_data  <= tx_byte_s;
              tx_idx_r <= tx_idx_r + 2'd1;
            end
          end
        end
        default: begin
          tx_start   <= 1'b0;
          Y_in_valid <= 1'b0;
          H_in_valid <= 1'b0;
          busy       <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soml_frame_sequencer.sv
// Directed testbench for soml_frame_sequencer with queue-based scoreboard.
module tb_soml_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_data_ready;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        dec_start;
  logic        H_in_valid;
  logic [31:0] H_in_r, H_in_i;
  logic        Y_in_valid;
  logic [31:0] Y_in_r, Y_in_i;
  logic        dec_out_valid;
  logic [11:0] dec_signal;
  logic [4:0]  dec_smin_index;
  logic        busy, frame_err, timeout_err;

  soml_frame_sequencer #(.N(32), .SYNC_BYTE(8'hA5), .DEC_TIMEOUT(16),
                         .ERR_CKSUM(8'hEE), .ERR_TMO(8'hEF)) dut (
    .clk(clk), .rst(rst), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .dec_start(dec_start), .H_in_valid(H_in_valid), .H_in_r(H_in_r), .H_in_i(H_in_i),
    .Y_in_valid(Y_in_valid), .Y_in_r(Y_in_r), .Y_in_i(Y_in_i),
    .dec_out_valid(dec_out_valid), .dec_signal(dec_signal),
    .dec_smin_index(dec_smin_index), .busy(busy), .frame_err(frame_err),
    .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] yq[$];
  logic [63:0] hq[$];
  logic [7:0]  txq[$];
  logic [31:0] fw [0:47];

  int cyc = 0, t_start = 0, y_seen = 0, h_seen = 0;
  int dec_seen = 0, exp_dec = 0, tx_pulses = 0;
  logic prev_ds = 1'b0;
  bit   bp_mode = 1'b0;
  int   bp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected words/bytes whenever the DUT strobes.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      cyc++;
      if (dec_start) begin
        check("dec_start_single_cycle", {63'd0, prev_ds}, 64'd0);
        dec_seen++;
        t_start = cyc;
        y_seen = 0;
        h_seen = 0;
      end
      prev_ds = dec_start;
      if (Y_in_valid || H_in_valid)
        check("y_h_exclusive", {63'd0, Y_in_valid & H_in_valid}, 64'd0);
      if (Y_in_valid) begin
        check("y_expected", {63'd0, yq.size() > 0}, 64'd1);
        if (yq.size() > 0) begin
          e = yq.pop_front();
          check("y_word", {Y_in_r, Y_in_i}, e);
        end
        check("y_timing", 64'(cyc), 64'(t_start + 2 + y_seen));
        y_seen++;
      end
      if (H_in_valid) begin
        check("h_expected", {63'd0, hq.size() > 0}, 64'd1);
        if (hq.size() > 0) begin
          e = hq.pop_front();
          check("h_word", {H_in_r, H_in_i}, e);
        end
        check("h_timing", 64'(cyc), 64'(t_start + 10 + h_seen));
        h_seen++;
      end
      if (tx_start) begin
        tx_pulses++;
        check("tx_expected", {63'd0, txq.size() > 0}, 64'd1);
        if (txq.size() > 0) begin
          e = {56'd0, txq.pop_front()};
          check("tx_byte", {56'd0, tx_data}, e);
        end
      end
    end else begin
      prev_ds = 1'b0;
    end
  end

  // Transmitter model: optional 100-cycle busy after each start.
  always @(negedge clk) begin
    if (tx_start) begin
      check("tx_start_not_busy", {63'd0, tx_busy}, 64'd0);
      if (bp_mode) begin
        tx_busy = 1'b1;
        bp_cnt = 100;
      end
    end else if (bp_cnt > 0) begin
      bp_cnt--;
      if (bp_cnt == 0) tx_busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data_ready = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic build_nominal();
    for (int i = 0; i < 16; i++) fw[i] = 32'h0040_0000;
    for (int j = 0; j < 16; j++) begin
      fw[16 + 2*j]     = ((j / 4) == (j % 4)) ? 32'h0040_0000 : 32'h0;
      fw[16 + 2*j + 1] = 32'h0;
    end
  endtask

  task automatic build_pattern();
    for (int i = 0; i < 48; i++)
      fw[i] = {8'(i*7 + 1), 8'(i*13 + 5), 8'(i ^ 8'h5A), 8'(255 - i)};
  endtask

  // Sends payload and checksum; pushes Y/H expectations for good frames.
  task automatic send_body(input bit bad);
    logic [7:0] cks;
    logic [31:0] w;
    cks = 8'h00;
    if (!bad) begin
      for (int k = 0; k < 8; k++) yq.push_back({fw[2*k], fw[2*k+1]});
      for (int j = 0; j < 16; j++) hq.push_back({fw[16+2*j], fw[17+2*j]});
      exp_dec++;
    end
    for (int i = 0; i < 48; i++) begin
      w = fw[i];
      for (int b = 3; b >= 0; b--) begin
        send_byte(w[8*b +: 8]);
        cks = cks ^ w[8*b +: 8];
      end
    end
    send_byte(bad ? (cks ^ 8'h01) : cks);
  endtask

  task automatic wait_h(input int target, output bit ok);
    int hc = 0;
    int n = 0;
    ok = 1'b0;
    while (hc < target && n < 200) begin
      @(posedge clk); #1;
      if (H_in_valid) hc++;
      n++;
    end
    ok = (hc == target);
    check("h_strobes_reached", {63'd0, ok}, 64'd1);
  endtask

  task automatic inject(input int delay, input logic [11:0] s, input logic [4:0] m);
    repeat (delay) @(posedge clk);
    #1;
    dec_out_valid = 1'b1;
    dec_signal = s;
    dec_smin_index = m;
    @(posedge clk); #1;
    dec_out_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_drops", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_yq_empty"}, 64'(yq.size()), 64'd0);
    check({tag, "_hq_empty"}, 64'(hq.size()), 64'd0);
    check({tag, "_txq_empty"}, 64'(txq.size()), 64'd0);
    check({tag, "_dec_starts"}, 64'(dec_seen), 64'(exp_dec));
  endtask

  initial begin
    bit ok;
    int p0;
    rst = 1'b1;
    rx_data_ready = 1'b0;
    rx_data = 8'h00;
    tx_busy = 1'b0;
    dec_out_valid = 1'b0;
    dec_signal = 12'h000;
    dec_smin_index = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {tx_start, dec_start, Y_in_valid, H_in_valid, busy, frame_err, timeout_err}, 64'd0);
    check("rst_tx_data", {56'd0, tx_data}, 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Nominal frame.
    build_nominal();
    send_byte(8'hA5);
    check("busy_after_sync", {63'd0, busy}, 64'd1);
    txq.push_back(8'h0A); txq.push_back(8'hBC); txq.push_back(8'h07);
    send_body(1'b0);
    wait_h(16, ok);
    if (ok) inject(3, 12'hABC, 5'd7);
    wait_idle(300);
    end_checks("nominal");
    check("nominal_flags", {62'd0, frame_err, timeout_err}, 64'd0);

    // Bad checksum.
    build_pattern();
    send_byte(8'hA5);
    txq.push_back(8'hEE);
    send_body(1'b1);
    wait_idle(300);
    end_checks("badcks");
    check("badcks_frame_err", {63'd0, frame_err}, 64'd1);

    // Noise ahead of sync, then a frame whose result lands on the last allowed wait cycle.
    send_byte(8'h00);
    send_byte(8'h13);
    check("noise_ignored", {62'd0, busy, frame_err}, 64'd1);
    send_byte(8'hA5);
    check("sync_clears_frame_err", {62'd0, busy, frame_err}, 64'd2);
    txq.push_back(8'h05); txq.push_back(8'hA3); txq.push_back(8'h1F);
    send_body(1'b0);
    wait_h(16, ok);
    if (ok) inject(16, 12'h5A3, 5'd31);
    wait_idle(300);
    end_checks("noise_boundary");
    check("boundary_no_timeout", {63'd0, timeout_err}, 64'd0);

    // Decoder timeout.
    build_nominal();
    send_byte(8'hA5);
    txq.push_back(8'hEF);
    send_body(1'b0);
    wait_h(16, ok);
    repeat (16) @(posedge clk);
    #1;
    check("tmo_not_yet", {62'd0, busy, timeout_err}, 64'd2);
    @(posedge clk); #1;
    check("tmo_set", {63'd0, timeout_err}, 64'd1);
    wait_idle(300);
    end_checks("timeout");

    // Backpressure; the sync byte also clears the timeout flag.
    bp_mode = 1'b1;
    build_pattern();
    send_byte(8'hA5);
    check("sync_clears_flags", {61'd0, busy, frame_err, timeout_err}, 64'd4);
    txq.push_back(8'h0A); txq.push_back(8'hBC); txq.push_back(8'h07);
    p0 = tx_pulses;
    send_body(1'b0);
    wait_h(16, ok);
    if (ok) inject(2, 12'hABC, 5'd7);
    wait_idle(1000);
    check("bp_three_pulses", 64'(tx_pulses - p0), 64'd3);
    end_checks("backpressure");
    bp_mode = 1'b0;

    // Async reset while H words are streaming.
    build_pattern();
    send_byte(8'hA5);
    send_body(1'b0);
    wait_h(5, ok);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_strobes", {60'd0, dec_start, Y_in_valid, H_in_valid, tx_start}, 64'd0);
    check("rst_mid_idle", {63'd0, busy}, 64'd0);
    yq.delete();
    hq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    check("after_rst_quiet", {62'd0, H_in_valid, Y_in_valid}, 64'd0);
    build_nominal();
    send_byte(8'hA5);
    txq.push_back(8'h01); txq.push_back(8'h23); txq.push_back(8'h04);
    send_body(1'b0);
    wait_h(16, ok);
    if (ok) inject(5, 12'h123, 5'd4);
    wait_idle(300);
    end_checks("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
